// File: rtl/perf_ctr_mmio.sv
// Branch-predictor performance counter block behind a small MMIO window.
// Holds event counters, a prescaled timer, a free-running LFSR and a one-cycle read port.
module perf_ctr_mmio #(
  parameter logic [15:0] BASE_ADDR = 16'hC000,
  parameter int          TMR_DIV   = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_br_cnt,
  input  logic        inc_hit_cnt,
  input  logic        inc_mispr_cnt,
  input  logic [15:0] addr,
  input  logic        re,
  input  logic        we,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        rd_valid
);

  localparam logic [7:0] DIV_LAST = 8'(TMR_DIV - 1);

  logic [15:0] r_br, r_hit, r_mispr, r_tmr;
  logic [15:0] r_sh_br, r_sh_hit, r_sh_mispr, r_sh_tmr;
  logic [7:0]  r_presc;
  logic [15:0] r_lfsr;
  logic        r_en;
  logic [3:0]  r_status;

  logic        w_win, w_rd, w_wr, w_clr, w_tick;
  logic        w_br_inc, w_hit_inc, w_mispr_inc;
  logic [2:0]  w_off;
  logic [3:0]  w_ovf;
  logic [15:0] w_lfsr_nxt, w_rmux;

  assign w_win = (addr[15:3] == BASE_ADDR[15:3]);
  assign w_off = addr[2:0];
  assign w_rd  = re & w_win;
  assign w_wr  = we & w_win;
  assign w_clr = w_wr && (w_off == 3'd5) && wdata[1];

  assign w_br_inc    = r_en & inc_br_cnt;
  assign w_hit_inc   = r_en & inc_hit_cnt;
  assign w_mispr_inc = r_en & inc_mispr_cnt;
  assign w_tick      = r_en && (r_presc == DIV_LAST);

  // A clear in the same cycle suppresses the wrap, so no sticky bit is raised.
  assign w_ovf[0] = w_br_inc    && (r_br    == 16'hFFFF) && !w_clr;
  assign w_ovf[1] = w_hit_inc   && (r_hit   == 16'hFFFF) && !w_clr;
  assign w_ovf[2] = w_mispr_inc && (r_mispr == 16'hFFFF) && !w_clr;
  assign w_ovf[3] = w_tick      && (r_tmr   == 16'hFFFF) && !w_clr;

  // Galois LFSR, x^16+x^15+x^13+x^4+1, shifting toward the MSB.
  assign w_lfsr_nxt = {r_lfsr[14:0], 1'b0} ^ (r_lfsr[15] ? 16'hA011 : 16'h0000);

  always_comb begin
    w_rmux = 16'h0000;
    case (w_off)
      3'd0:    w_rmux = r_br;
      3'd1:    w_rmux = r_sh_hit;
      3'd2:    w_rmux = r_sh_mispr;
      3'd3:    w_rmux = r_sh_tmr;
      3'd4:    w_rmux = r_lfsr;
      3'd5:    w_rmux = {15'h0000, r_en};
      3'd6:    w_rmux = {12'h000, r_status};
      default: w_rmux = 16'h0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_br       <= '0;
      r_hit      <= '0;
      r_mispr    <= '0;
      r_tmr      <= '0;
      r_presc    <= '0;
      r_sh_br    <= '0;
      r_sh_hit   <= '0;
      r_sh_mispr <= '0;
      r_sh_tmr   <= '0;
      r_lfsr     <= LFSR_SEED;
      r_en       <= 1'b1;
      r_status   <= '0;
      rdata      <= '0;
      rd_valid   <= 1'b0;
    end else begin
      if (w_clr) begin
        r_br    <= '0;
        r_hit   <= '0;
        r_mispr <= '0;
        r_tmr   <= '0;
        r_presc <= '0;
      end else begin
        if (w_br_inc)    r_br    <= r_br + 16'd1;
        if (w_hit_inc)   r_hit   <= r_hit + 16'd1;
        if (w_mispr_inc) r_mispr <= r_mispr + 16'd1;
        if (r_en) begin
          if (w_tick) begin
            r_presc <= '0;
            r_tmr   <= r_tmr + 16'd1;
          end else begin
            r_presc <= r_presc + 8'd1;
          end
        end
      end

      // A CTRL write carrying CLR is a clear command only; EN keeps its value.
      if (w_wr && (w_off == 3'd5) && !wdata[1]) r_en <= wdata[0];

      if (w_wr && (w_off == 3'd6)) r_status <= (r_status & ~wdata[3:0]) | w_ovf;
      else                         r_status <= r_status | w_ovf;

      if (w_wr && (w_off == 3'd4)) r_lfsr <= (wdata == 16'h0000) ? LFSR_SEED : wdata;
      else                         r_lfsr <= w_lfsr_nxt;

      if (w_rd && (w_off == 3'd0)) begin
        r_sh_br    <= r_br;
        r_sh_hit   <= r_hit;
        r_sh_mispr <= r_mispr;
        r_sh_tmr   <= r_tmr;
      end

      rd_valid <= w_rd;
      rdata    <= w_rd ? w_rmux : 16'h0000;
    end
  end

endmodule

// File: tb/tb_perf_ctr_mmio.sv
// Directed bench for perf_ctr_mmio: reset, counting, wrap/W1C, clear race, timer, LFSR, window edges.
module tb_perf_ctr_mmio;
  localparam logic [15:0] BASE = 16'hC000;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inc_br_cnt = 1'b0, inc_hit_cnt = 1'b0, inc_mispr_cnt = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic        re = 1'b0, we = 1'b0;
  logic [15:0] wdata = 16'h0000;
  logic [15:0] rdata;
  logic        rd_valid;

  int n_chk = 0;
  int n_pass = 0;

  perf_ctr_mmio #(.BASE_ADDR(BASE), .TMR_DIV(4), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst(rst),
    .inc_br_cnt(inc_br_cnt), .inc_hit_cnt(inc_hit_cnt), .inc_mispr_cnt(inc_mispr_cnt),
    .addr(addr), .re(re), .we(we), .wdata(wdata),
    .rdata(rdata), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    logic [15:0] y;
    y = x << 1;
    if (x[15]) y = y ^ 16'hA011;
    return y;
  endfunction

  // Single read: strobe at a negedge, sample at the next negedge.
  task automatic rd(input logic [2:0] off, output logic [15:0] d, output logic v);
    addr = BASE | {13'h0, off};
    re = 1'b1;
    @(negedge clk);
    d = rdata;
    v = rd_valid;
    re = 1'b0;
  endtask

  task automatic wr(input logic [2:0] off, input logic [15:0] val);
    addr = BASE | {13'h0, off};
    wdata = val;
    we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] exp_d [6];
    logic [2:0]  offs [6];
    logic [15:0] l;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if (rdata !== 16'h0 || rd_valid !== 1'b0) $display("FAIL reset_out rdata=%h vld=%b exp 0000/0", rdata, rd_valid);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    offs[0] = 3'd0; offs[1] = 3'd1; offs[2] = 3'd2; offs[3] = 3'd3; offs[4] = 3'd5; offs[5] = 3'd4;
    l = SEED;
    for (int k = 0; k < 6; k++) l = lfsr_step(l);
    exp_d[0] = 16'h0; exp_d[1] = 16'h0; exp_d[2] = 16'h0; exp_d[3] = 16'h0; exp_d[4] = 16'h1; exp_d[5] = l;
    for (int i = 0; i <= 6; i++) begin
      if (i > 0) begin
        n_chk++;
        if (rdata !== exp_d[i-1] || rd_valid !== 1'b1)
          $display("FAIL reset_read%0d rdata=%h vld=%b exp %h/1", i-1, rdata, rd_valid, exp_d[i-1]);
        else n_pass++;
      end
      if (i < 6) begin
        addr = BASE | {13'h0, offs[i]};
        re = 1'b1;
      end else re = 1'b0;
      @(negedge clk);
    end
    n_chk++;
    if (rd_valid !== 1'b0 || rdata !== 16'h0) $display("FAIL idle_after_reads rdata=%h vld=%b exp 0000/0", rdata, rd_valid);
    else n_pass++;
  endtask

  task automatic test_counting();
    logic [15:0] d;
    logic v;
    inc_br_cnt = 1'b1;    repeat (10) @(negedge clk); inc_br_cnt = 1'b0;
    inc_hit_cnt = 1'b1;   repeat (7)  @(negedge clk); inc_hit_cnt = 1'b0;
    inc_mispr_cnt = 1'b1; repeat (3)  @(negedge clk); inc_mispr_cnt = 1'b0;
    rd(3'd0, d, v);
    n_chk++;
    if (d !== 16'd10 || v !== 1'b1) $display("FAIL br_count got %h/%b exp 000a/1", d, v);
    else n_pass++;
    inc_hit_cnt = 1'b1; inc_mispr_cnt = 1'b1; repeat (2) @(negedge clk);
    inc_hit_cnt = 1'b0; inc_mispr_cnt = 1'b0;
    rd(3'd1, d, v);
    n_chk++;
    if (d !== 16'd7 || v !== 1'b1) $display("FAIL hit_snapshot got %h/%b exp 0007/1", d, v);
    else n_pass++;
    inc_mispr_cnt = 1'b1; @(negedge clk); inc_mispr_cnt = 1'b0;
    rd(3'd2, d, v);
    n_chk++;
    if (d !== 16'd3 || v !== 1'b1) $display("FAIL mispr_snapshot got %h/%b exp 0003/1", d, v);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [15:0] d;
    logic v;
    wr(3'd5, 16'h0002);
    inc_br_cnt = 1'b1; repeat (65535) @(negedge clk); inc_br_cnt = 1'b0;
    rd(3'd6, d, v);
    n_chk++;
    if (d !== 16'h0000) $display("FAIL status_pre_wrap got %h exp 0000", d);
    else n_pass++;
    rd(3'd0, d, v);
    n_chk++;
    if (d !== 16'hFFFF) $display("FAIL br_full got %h exp ffff", d);
    else n_pass++;
    // Wrapping pulse coincides with a W1C of the same bit: the new overflow must win.
    inc_br_cnt = 1'b1; addr = BASE | 16'h6; wdata = 16'h0001; we = 1'b1;
    @(negedge clk);
    inc_br_cnt = 1'b0; we = 1'b0;
    rd(3'd6, d, v);
    n_chk++;
    if (d !== 16'h0001) $display("FAIL status_wrap got %h exp 0001", d);
    else n_pass++;
    rd(3'd0, d, v);
    n_chk++;
    if (d !== 16'h0000) $display("FAIL br_wrapped got %h exp 0000", d);
    else n_pass++;
    wr(3'd6, 16'h0001);
    rd(3'd6, d, v);
    n_chk++;
    if (d !== 16'h0000) $display("FAIL status_w1c got %h exp 0000", d);
    else n_pass++;
  endtask

  task automatic test_clr_race();
    logic [15:0] d;
    logic v;
    wr(3'd5, 16'h0002);
    inc_hit_cnt = 1'b1; repeat (5) @(negedge clk); inc_hit_cnt = 1'b0;
    rd(3'd0, d, v);
    rd(3'd1, d, v);
    n_chk++;
    if (d !== 16'd5) $display("FAIL hit_five got %h exp 0005", d);
    else n_pass++;
    inc_hit_cnt = 1'b1; addr = BASE | 16'h5; wdata = 16'h0002; we = 1'b1;
    @(negedge clk);
    inc_hit_cnt = 1'b0; we = 1'b0;
    rd(3'd0, d, v);
    n_chk++;
    if (d !== 16'h0000) $display("FAIL clr_br got %h exp 0000", d);
    else n_pass++;
    rd(3'd1, d, v);
    n_chk++;
    if (d !== 16'h0000) $display("FAIL clr_hit_race got %h exp 0000", d);
    else n_pass++;
    rd(3'd5, d, v);
    n_chk++;
    if (d !== 16'h0001) $display("FAIL ctrl_after_clr got %h exp 0001", d);
    else n_pass++;
  endtask

  task automatic test_timer();
    logic [15:0] d;
    logic v;
    wr(3'd5, 16'h0002);
    repeat (39) @(negedge clk);
    wr(3'd5, 16'h0000);
    repeat (20) @(negedge clk);
    rd(3'd0, d, v);
    rd(3'd3, d, v);
    n_chk++;
    if (d !== 16'd10) $display("FAIL timer got %h exp 000a", d);
    else n_pass++;
    rd(3'd5, d, v);
    n_chk++;
    if (d !== 16'h0000) $display("FAIL ctrl_disabled got %h exp 0000", d);
    else n_pass++;
    wr(3'd5, 16'h0001);
  endtask

  task automatic test_lfsr_misc();
    logic [15:0] d;
    logic v;
    wr(3'd4, 16'h0000);
    @(negedge clk);
    rd(3'd4, d, v);
    n_chk++;
    if (d !== lfsr_step(SEED)) $display("FAIL lfsr_zero_seed got %h exp %h", d, lfsr_step(SEED));
    else n_pass++;
    // Read and write of CTRL in one cycle: read sees the old EN.
    addr = BASE | 16'h5; wdata = 16'h0000; re = 1'b1; we = 1'b1;
    @(negedge clk);
    d = rdata;
    re = 1'b0; we = 1'b0;
    n_chk++;
    if (d !== 16'h0001) $display("FAIL rw_same_old got %h exp 0001", d);
    else n_pass++;
    rd(3'd5, d, v);
    n_chk++;
    if (d !== 16'h0000) $display("FAIL rw_same_new got %h exp 0000", d);
    else n_pass++;
    wr(3'd5, 16'h0001);
    addr = BASE + 16'd8; re = 1'b1;
    @(negedge clk);
    re = 1'b0;
    n_chk++;
    if (rd_valid !== 1'b0 || rdata !== 16'h0) $display("FAIL out_of_window_rd rdata=%h vld=%b exp 0000/0", rdata, rd_valid);
    else n_pass++;
    addr = BASE + 16'd13; wdata = 16'h0000; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
    rd(3'd5, d, v);
    n_chk++;
    if (d !== 16'h0001) $display("FAIL out_of_window_wr got %h exp 0001", d);
    else n_pass++;
  endtask

  task automatic test_reset_midread();
    logic [15:0] d;
    logic v;
    wr(3'd5, 16'h0000);
    addr = BASE | 16'h4; re = 1'b1; rst = 1'b1;
    @(negedge clk);
    re = 1'b0; rst = 1'b0;
    n_chk++;
    if (rd_valid !== 1'b0 || rdata !== 16'h0) $display("FAIL rst_midread rdata=%h vld=%b exp 0000/0", rdata, rd_valid);
    else n_pass++;
    rd(3'd5, d, v);
    n_chk++;
    if (d !== 16'h0001 || v !== 1'b1) $display("FAIL ctrl_after_rst got %h/%b exp 0001/1", d, v);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_counting();
    test_wrap();
    test_clr_race();
    test_timer();
    test_lfsr_misc();
    test_reset_midread();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_chk);
    $fatal(1);
  end
endmodule
